// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational integer ALU between two requesters,
// with a registered, handshaked result per port. Define ALU_SHARE_ARB_STATS_EN for grant/conflict counters.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]      stat_grant0,
    output logic [15:0]      stat_grant1,
    output logic [15:0]      stat_conflict
`endif
);

    logic             rr_q, rr_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;

    logic slotFree0, slotFree1;
    logic elig0, elig1;
    logic grant0, grant1;

    // A held result that drains this cycle frees its slot for a new grant.
    assign slotFree0 = ~rsp0_valid_q | rsp0_ready;
    assign slotFree1 = ~rsp1_valid_q | rsp1_ready;
    assign elig0     = req0_valid & slotFree0;
    assign elig1     = req1_valid & slotFree1;

    assign grant0 = elig0 & (~elig1 | ~rr_q);
    assign grant1 = elig1 & (~elig0 |  rr_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 4'b0000;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_sel;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_sel;
        end
    end

    always_comb begin
        rr_d         = rr_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;

        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end

        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_out;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_out;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rr_q         <= rr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;
    logic [15:0] stat_conflict_q, stat_conflict_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_grant0_d   = stat_grant0_q;
        stat_grant1_d   = stat_grant1_q;
        stat_conflict_d = stat_conflict_q;
        if (grant0 && stat_grant0_q != 16'hFFFF) begin
            stat_grant0_d = stat_grant0_q + 16'd1;
        end
        if (grant1 && stat_grant1_q != 16'hFFFF) begin
            stat_grant1_d = stat_grant1_q + 16'd1;
        end
        if (elig0 && elig1 && stat_conflict_q != 16'hFFFF) begin
            stat_conflict_d = stat_conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level model. Stats checks need ALU_SHARE_ARB_STATS_EN.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [W-1:0] req0_a, req0_b, rsp0_data;
    logic [3:0]   req0_sel;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] req1_a, req1_b, rsp1_data;
    logic [3:0]   req1_sel;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0]  stat_grant0, stat_grant1, stat_conflict;
`endif

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Transaction-level model: preferred port, held result per port, stats.
    bit          mKnown = 1'b0;
    int          mRr = 0;
    bit          mV[2];
    logic [31:0] mD[2];
    int          mG[2];
    int          mConf = 0;
    logic        lastReady0, lastReady1;

    always #5 clk = ~clk;

    // Stand-in ALU with the usual integer encoding; unknown codes give zero.
    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a << b[4:0];
            4'b0011: return a >> b[4:0];
            4'b0100: return $unsigned($signed(a) >>> b[4:0]);
            4'b0101: return a & b;
            4'b0110: return a | b;
            4'b0111: return a ^ b;
            4'b1000: return (a < b) ? 32'd1 : 32'd0;
            4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = aluRef(alu_a, alu_b, alu_sel);

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
`ifdef ALU_SHARE_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // Drives one cycle just after a rising edge, checks before the next one, then advances the model.
    task automatic applyStimulus(input bit rst,
                                 input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0, input bit r0,
                                 input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1, input bit r1);
        logic [31:0] ka[2], kb[2];
        logic [3:0]  ks[2];
        bit          e[2], rd[2];
        int          win;
        reset = rst;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0; rsp0_ready = r0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1; rsp1_ready = r1;
        ka[0] = a0; kb[0] = b0; ks[0] = s0; ka[1] = a1; kb[1] = b1; ks[1] = s1;
        rd[0] = r0; rd[1] = r1;
        e[0] = v0 && (!mV[0] || r0);
        e[1] = v1 && (!mV[1] || r1);
        if (e[0] && e[1]) win = mRr;
        else if (e[0])    win = 0;
        else if (e[1])    win = 1;
        else              win = -1;
        #3;
        lastReady0 = req0_ready;
        lastReady1 = req1_ready;
        if (mKnown) begin
            checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
            checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
            checkOutput("alu_a", alu_a, (win >= 0) ? ka[win] : 32'd0);
            checkOutput("alu_b", alu_b, (win >= 0) ? kb[win] : 32'd0);
            checkOutput("alu_sel", {28'd0, alu_sel}, (win >= 0) ? {28'd0, ks[win]} : 32'd0);
            checkOutput("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, mV[0]});
            checkOutput("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, mV[1]});
            checkOutput("rsp0_data", rsp0_data, mD[0]);
            checkOutput("rsp1_data", rsp1_data, mD[1]);
`ifdef ALU_SHARE_ARB_STATS_EN
            checkOutput("stat_grant0", {16'd0, stat_grant0}, mG[0]);
            checkOutput("stat_grant1", {16'd0, stat_grant1}, mG[1]);
            checkOutput("stat_conflict", {16'd0, stat_conflict}, mConf);
`endif
        end
        @(posedge clk);
        if (rst) begin
            mKnown = 1'b1;
            mRr = 0;
            mConf = 0;
            for (int k = 0; k < 2; k++) begin
                mV[k] = 1'b0;
                mD[k] = 32'd0;
                mG[k] = 0;
            end
        end else if (mKnown) begin
            for (int k = 0; k < 2; k++) begin
                if (win == k) begin
                    mV[k] = 1'b1;
                    mD[k] = aluRef(ka[k], kb[k], ks[k]);
                    if (mG[k] < 65535) mG[k]++;
                end else if (rd[k]) begin
                    mV[k] = 1'b0;
                end
            end
            if (e[0] && e[1] && mConf < 65535) mConf++;
            if (win >= 0) mRr = 1 - win;
        end
        #1;
    endtask

    task automatic idle(input bit rst);
        applyStimulus(rst, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit          hold0, hold1, pv0, pv1;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [3:0]  rs0, rs1;

        reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0; rsp1_ready = 0;
        @(posedge clk);
        #1;

        phase = "reset";
        idle(1);
        idle(1);
        idle(0);

        phase = "single_add";
        applyStimulus(0, 1, 5, 3, 4'b0000, 1, 0, 0, 0, 0, 1);
        checkOutput("grant_cycle0", {31'd0, lastReady0}, 1);
        checkOutput("valid_next", {31'd0, rsp0_valid}, 1);
        checkOutput("data_next", rsp0_data, 8);
        idle(0);

        phase = "alternate";
        idle(1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 10, 4, 4'b0001, 1, 1, 32'hF0, 32'h3C, 4'b0101, 1);
            checkOutput($sformatf("grant0_step%0d", i), {31'd0, lastReady0}, {31'd0, (i % 2) == 0});
            checkOutput($sformatf("grant1_step%0d", i), {31'd0, lastReady1}, {31'd0, (i % 2) == 1});
        end
        checkOutput("sub_result", rsp0_data, 6);
        checkOutput("and_result", rsp1_data, 32'h30);

        phase = "stall";
        applyStimulus(0, 1, 7, 2, 4'b0000, 1, 1, 1, 1, 4'b0000, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 100, 1, 4'b0000, 0, 1, 20 + i, 1, 4'b0000, 1);
            checkOutput($sformatf("stalled_no_grant%0d", i), {31'd0, lastReady0}, 0);
            checkOutput($sformatf("other_granted%0d", i), {31'd0, lastReady1}, 1);
            checkOutput($sformatf("held_data%0d", i), rsp0_data, 9);
        end
        applyStimulus(0, 1, 100, 1, 4'b0000, 1, 1, 30, 1, 4'b0000, 1);
        checkOutput("drain_grant", {31'd0, lastReady0}, 1);
        checkOutput("drain_data", rsp0_data, 101);
        idle(0);

        phase = "back_to_back";
        applyStimulus(0, 1, 1, 1, 4'b0000, 1, 0, 0, 0, 0, 1);
        checkOutput("b2b_valid1", {31'd0, rsp0_valid}, 1);
        checkOutput("b2b_data1", rsp0_data, 2);
        applyStimulus(0, 1, 32'hFFFF_FFFF, 1, 4'b1001, 1, 0, 0, 0, 0, 1);
        checkOutput("b2b_valid2", {31'd0, rsp0_valid}, 1);
        checkOutput("b2b_data2", rsp0_data, 1);
        idle(0);

        phase = "reset_midop";
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 4, 4, 4'b0000, 0);
        checkOutput("rsp1_held", {31'd0, rsp1_valid}, 1);
        applyStimulus(1, 1, 3, 3, 4'b0000, 1, 0, 0, 0, 0, 0);
        checkOutput("rst_v0", {31'd0, rsp0_valid}, 0);
        checkOutput("rst_v1", {31'd0, rsp1_valid}, 0);
        checkOutput("rst_d0", rsp0_data, 0);
        applyStimulus(0, 1, 2, 2, 4'b0000, 1, 1, 3, 3, 4'b0000, 1);
        checkOutput("post_rst_first", {31'd0, lastReady0}, 1);
        idle(0);

`ifdef ALU_SHARE_ARB_STATS_EN
        phase = "stats";
        idle(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, i, 1, 4'b0000, 1, 1, i, 2, 4'b0110, 1);
        end
        checkOutput("grant0_cnt", {16'd0, stat_grant0}, 5);
        checkOutput("grant1_cnt", {16'd0, stat_grant1}, 5);
        checkOutput("conflict_cnt", {16'd0, stat_conflict}, 10);
        idle(1);
        checkOutput("grant0_clr", {16'd0, stat_grant0}, 0);
        checkOutput("conflict_clr", {16'd0, stat_conflict}, 0);
`endif

        phase = "random";
        hold0 = 0; hold1 = 0; pv0 = 0; pv1 = 0;
        ra0 = 0; rb0 = 0; rs0 = 0; ra1 = 0; rb1 = 0; rs1 = 0;
        for (int i = 0; i < 400; i++) begin
            bit rst;
            rst = ($urandom_range(0, 59) == 0);
            if (!hold0) begin
                pv0 = $urandom_range(0, 3) != 0;
                ra0 = $urandom; rb0 = $urandom; rs0 = 4'($urandom_range(0, 15));
            end
            if (!hold1) begin
                pv1 = $urandom_range(0, 3) != 0;
                ra1 = $urandom; rb1 = $urandom; rs1 = 4'($urandom_range(0, 15));
            end
            applyStimulus(rst, pv0, ra0, rb0, rs0, $urandom_range(0, 2) != 0,
                               pv1, ra1, rb1, rs1, $urandom_range(0, 2) != 0);
            hold0 = pv0 && !lastReady0;
            hold1 = pv1 && !lastReady1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters:
  - port 0: execute-stage integer ops.
  - port 1: auxiliary address/branch-target generation.
- Round-robin arbitration, with a valid/ready handshake on each request and response port.
- Drives the ALU operand and select inputs and captures the ALU result into a per-port output register.
- Fixed 1-cycle latency from grant to response.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle (grant).
- req0_a  in  WIDTH  port 0 operand A.
- req0_b  in  WIDTH  port 0 operand B.
- req0_sel  in  4  port 0 ALU select code (ALU encoding, e.g. 0000 add, 0001 sub, 1001 signed SLT).
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 consumer ready.
- rsp0_data  out  WIDTH  port 0 result.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_sel  out  4  ALU select.
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).

Behaviour:
- Slot free for port k: slot_free_k = ~rsp_k_valid | rsp_k_ready.
  - A result held in the register may drain in the same cycle a new op is granted.
- Eligible for port k: elig_k = req_k_valid & slot_free_k.
- Round-robin pointer rr (1 bit) names the preferred port:
  - Only one port eligible: that port is granted.
  - Both eligible: port rr is granted.
  - After any grant, rr = ~winner.
  - No grant: rr unchanged.
- req_k_ready = grant_k. It is combinational and asserts only when req_k_valid is high; at most one grant per cycle.
- ALU drive is combinational:
  - On grant: alu_a/alu_b/alu_sel = the winner's a/b/sel.
  - No grant: all three = 0 (idle add of zero).
- Result capture at the edge following a grant on port k:
  - rsp_k_data <= alu_out.
  - rsp_k_valid <= 1.
- Handshake completion on port k with no new grant to k: rsp_k_valid <= 0. rsp_k_data holds its last value.
- Same-cycle handshake and new grant on port k: rsp_k_valid stays 1 and rsp_k_data takes the new result, so back-to-back throughput is 1 op/cycle per port.
- A port whose rsp is stalled (valid & ~ready) is not eligible. The other port may be granted every cycle meanwhile.
- Reset:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - rr = 0 (port 0 preferred first).
  - Combinational outputs follow from these values.
  - Reset mid-operation discards any held results; a request granted in the reset cycle is dropped.
- Requesters must hold a/b/sel stable while valid and not ready. The block does not latch request operands.
- Undefined sel codes are passed through unchanged; the ALU default applies.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs stat_grant0 (16), stat_grant1 (16) and stat_conflict (16).
  - stat_grant0/stat_grant1 increment on each grant to port 0/1.
  - stat_conflict increments in each cycle both ports are eligible.
  - All counters saturate at 16'hFFFF and clear on reset.
- Without the macro: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then req0 a=5 b=3 sel=0000 with rsp0_ready=1 -> req0_ready=1 in cycle 0; next cycle rsp0_valid=1, rsp0_data=8; alu_* = 0 when idle.
- Both requesters valid every cycle, both rsp_ready=1:
  - req0 sel=0001 a=10 b=4, req1 sel=0101 a=0xF0 b=0x3C.
  - Grants alternate 0,1,0,1 starting with port 0.
  - rsp0_data=6, rsp1_data=0x30.
- rsp0_ready=0 while rsp0_valid=1, both requesting -> port 1 granted every cycle; port 0 never granted, rsp0_data held; when rsp0_ready rises, port 0 is granted the same cycle.
- Back-to-back port 0 ops (add 1+1, then signed SLT a=0xFFFFFFFF b=1) with rsp0_ready=1 -> rsp0_valid stays 1 for two cycles; data 2 then 1.
- Assert reset while rsp1_valid=1 and req0 is being granted -> next cycle rsp0_valid=rsp1_valid=0, rr=0; after release, simultaneous requests grant port 0 first.
- With ALU_SHARE_ARB_STATS_EN: 10 cycles of both requesting -> stat_grant0=5, stat_grant1=5, stat_conflict=10; counters return to 0 after reset.
